// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REFILL     = 2'd1,
      WRITE_THRU = 2'd2
   } cache_state_t;

   localparam int          BYTE_LANES  = 4;
   localparam int          OFFSET_BITS = 2;
   localparam logic [3:0]  LANES_ALL   = 4'hF;

   // A single-word line has no word index bits; callers size their index signals to at least 1 bit.
   function automatic int word_index_bits(input int words_per_line);
      return (words_per_line > 1) ? $clog2(words_per_line) : 0;
   endfunction

   function automatic int line_index_bits(input int num_lines);
      return (num_lines > 1) ? $clog2(num_lines) : 1;
   endfunction

   function automatic int tag_bits(input int addr_width, input int num_lines, input int words_per_line);
      return addr_width - OFFSET_BITS - word_index_bits(words_per_line) - line_index_bits(num_lines);
   endfunction

   function automatic logic [3:0] lane_enable(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage: combinational read port, synchronous word/byte write port.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int TAG_W          = 24,
   parameter int LINE_W         = 4,
   parameter int WORD_W         = 2
) (
   input  logic              clk,
   input  logic              clear_valid,
   input  logic [LINE_W-1:0] rd_line,
   input  logic [WORD_W-1:0] rd_word,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [31:0]       rd_data,
   input  logic              wr_en,
   input  logic [LINE_W-1:0] wr_line,
   input  logic [WORD_W-1:0] wr_word,
   input  logic [3:0]        wr_be,
   input  logic [31:0]       wr_data,
   input  logic              set_valid,
   input  logic [TAG_W-1:0]  set_tag
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

   assign rd_valid = valid_q[rd_line];
   assign rd_tag   = tag_q[rd_line];
   assign rd_data  = data_q[rd_line][rd_word];

   always_ff @(posedge clk) begin
      if (clear_valid) begin
         valid_q <= '0;
      end else if (set_valid) begin
         valid_q[wr_line] <= 1'b1;
      end
   end

   // Tag and data are deliberately left unreset; the valid bits alone gate hits.
   always_ff @(posedge clk) begin
      if (set_valid) begin
         tag_q[wr_line] <= set_tag;
      end
      if (wr_en) begin
         for (int b = 0; b < BYTE_LANES; b++) begin
            if (wr_be[b]) begin
               data_q[wr_line][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack backing memory port.
//   state      | meaning
//   IDLE       | serving read hits; detects read misses and stores
//   REFILL     | fetching the whole line word by word, then marking it valid
//   WRITE_THRU | forwarding a store to memory; updates the cached copy on a hit
module data_cache
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic                  write_or_byte,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [31:0]           cpu_write_data,
   output logic [31:0]           cpu_read_data,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   output logic                  mem_byte,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_read_data
);

   localparam int WORD_BITS = word_index_bits(WORDS_PER_LINE);
   localparam int WORD_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
   localparam int LINE_W    = line_index_bits(NUM_LINES);
   localparam int TAG_W     = tag_bits(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);

   cache_state_t state_q, state_d;

   logic [LINE_W-1:0]     cpu_line;
   logic [WORD_W-1:0]     cpu_word;
   logic [TAG_W-1:0]      cpu_tag;
   logic [WORD_W-1:0]     refill_word;
   logic [WORD_W-1:0]     words_left;
   logic [ADDR_WIDTH-1:0] line_base;

   logic                  rd_valid;
   logic [TAG_W-1:0]      rd_tag;
   logic [31:0]           rd_data;
   logic                  hit;

   logic                  refill_we, thru_we, last_word;
   logic                  wr_en, set_valid;
   logic [WORD_W-1:0]     wr_word;
   logic [3:0]            wr_be;
   logic [31:0]           wr_data;

   assign cpu_line    = LINE_W'(cpu_address >> (OFFSET_BITS + WORD_BITS));
   assign cpu_word    = (WORD_BITS == 0) ? '0 : WORD_W'(cpu_address >> OFFSET_BITS);
   assign cpu_tag     = TAG_W'(cpu_address >> (OFFSET_BITS + WORD_BITS + LINE_W));
   assign refill_word = (WORD_BITS == 0) ? '0 : WORD_W'(mem_address >> OFFSET_BITS);
   assign line_base   = cpu_address & ~ADDR_WIDTH'(BYTE_LANES * WORDS_PER_LINE - 1);

   assign hit       = rd_valid && (rd_tag == cpu_tag);
   assign last_word = (words_left == '0);

   // Array writes are masked while reset is low so an abandoned transfer leaves no trace.
   assign refill_we = reset && (state_q == REFILL) && mem_ack;
   assign thru_we   = reset && (state_q == WRITE_THRU) && mem_ack && hit;
   assign wr_en     = refill_we || thru_we;
   assign set_valid = refill_we && last_word;
   assign wr_word   = refill_we ? refill_word : cpu_word;
   assign wr_be     = (refill_we || !write_or_byte) ? LANES_ALL : lane_enable(cpu_address[1:0]);
   assign wr_data   = refill_we     ? mem_read_data :
                      write_or_byte ? {4{cpu_write_data[7:0]}} : cpu_write_data;

   cache_line_store #(
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_W          (TAG_W),
      .LINE_W         (LINE_W),
      .WORD_W         (WORD_W)
   ) u_store (
      .clk         (clk),
      .clear_valid (!reset),
      .rd_line     (cpu_line),
      .rd_word     (cpu_word),
      .rd_valid    (rd_valid),
      .rd_tag      (rd_tag),
      .rd_data     (rd_data),
      .wr_en       (wr_en),
      .wr_line     (cpu_line),
      .wr_word     (wr_word),
      .wr_be       (wr_be),
      .wr_data     (wr_data),
      .set_valid   (set_valid),
      .set_tag     (cpu_tag)
   );

   assign cpu_read_data = (state_q == IDLE && cpu_read && hit) ? rd_data : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_write) begin
               stall   = 1'b1;
               state_d = WRITE_THRU;
            end else if (cpu_read && !hit) begin
               stall   = 1'b1;
               state_d = REFILL;
            end
         end
         REFILL: begin
            stall = 1'b1;
            if (mem_ack && last_word) begin
               state_d = IDLE;
            end
         end
         WRITE_THRU: begin
            stall = !mem_ack;
            if (mem_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request side is registered; words_left is a down-counter whose terminal count ends the refill.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_req        <= 1'b0;
         mem_write      <= 1'b0;
         mem_byte       <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         words_left     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_write) begin
                  mem_req        <= 1'b1;
                  mem_write      <= 1'b1;
                  mem_byte       <= write_or_byte;
                  mem_address    <= cpu_address;
                  mem_write_data <= cpu_write_data;
               end else if (cpu_read && !hit) begin
                  mem_req     <= 1'b1;
                  mem_write   <= 1'b0;
                  mem_byte    <= 1'b0;
                  mem_address <= line_base;
                  words_left  <= WORD_W'(WORDS_PER_LINE - 1);
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  if (last_word) begin
                     mem_req <= 1'b0;
                  end else begin
                     mem_address <= mem_address + ADDR_WIDTH'(BYTE_LANES);
                     words_left  <= words_left - WORD_W'(1);
                  end
               end
            end
            WRITE_THRU: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
               end
            end
            default: mem_req <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: transaction-level cache/memory model plus per-cycle compare.
module tb_data_cache;

   localparam int AW  = 32;
   localparam int NL  = 16;
   localparam int WPL = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_read, cpu_write, write_or_byte;
   logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
   logic        stall, mem_req, mem_write, mem_byte, mem_ack;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   always #5 clk = ~clk;

   data_cache #(
      .ADDR_WIDTH     (AW),
      .NUM_LINES      (NL),
      .WORDS_PER_LINE (WPL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_read       (cpu_read),
      .cpu_write      (cpu_write),
      .write_or_byte  (write_or_byte),
      .cpu_address    (cpu_address),
      .cpu_write_data (cpu_write_data),
      .cpu_read_data  (cpu_read_data),
      .stall          (stall),
      .mem_req        (mem_req),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_byte       (mem_byte),
      .mem_ack        (mem_ack),
      .mem_read_data  (mem_read_data)
   );

   int checks    = 0;
   int failures  = 0;
   int stall_cnt = 0;

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_write, exp_byte;
   logic [31:0] exp_rdata, exp_addr, exp_wdata;

   // Reference model: cache contents and backing memory (unwritten words read back as their address).
   bit          m_valid [NL];
   int unsigned m_tag   [NL];
   logic [31:0] m_data  [NL][WPL];
   logic [31:0] mem     [int unsigned];

   function automatic int f_line(input logic [31:0] a);
      return int'((a / (4 * WPL)) % NL);
   endfunction
   function automatic int f_word(input logic [31:0] a);
      return int'((a / 4) % WPL);
   endfunction
   function automatic int unsigned f_tag(input logic [31:0] a);
      return a / (4 * WPL * NL);
   endfunction
   function automatic logic [31:0] memrd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : a;
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input bit byt, input logic [31:0] a);
      logic [31:0] r;
      r = old;
      if (byt) r[8 * (a % 4) +: 8] = d[7:0];
      else     r = d;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (stall === 1'b1) stall_cnt++;
         chk("stall", 32'(stall), 32'(exp_stall));
         chk("cpu_read_data", cpu_read_data, exp_rdata);
         chk("mem_req", 32'(mem_req), 32'(exp_req));
         if (exp_req) begin
            chk("mem_address", mem_address, exp_addr);
            chk("mem_write", 32'(mem_write), 32'(exp_write));
            if (exp_write) begin
               chk("mem_write_data", mem_write_data, exp_wdata);
               chk("mem_byte", 32'(mem_byte), 32'(exp_byte));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_exp();
      exp_stall = 1'b0; exp_rdata = '0; exp_req = 1'b0;
      exp_write = 1'b0; exp_byte = 1'b0; exp_addr = '0; exp_wdata = '0;
   endtask

   // One CPU access, with the bench acting as backing memory; lat < 0 picks a random wait per word.
   task automatic op(input bit wr, input bit byt, input logic [31:0] a,
                     input logic [31:0] d, input int lat);
      int          l, ln, wd;
      bit          hit;
      logic [31:0] base;
      ln   = f_line(a);
      wd   = f_word(a);
      hit  = m_valid[ln] && (m_tag[ln] == f_tag(a));
      base = a - (a % (4 * WPL));
      stall_cnt      = 0;
      cpu_address    = a;
      cpu_write_data = d;
      write_or_byte  = byt;
      cpu_write      = wr;
      cpu_read       = !wr;
      idle_exp();
      if (!wr && hit) begin
         exp_rdata = m_data[ln][wd];
         step();
      end else if (!wr) begin
         exp_stall = 1'b1;
         step();
         for (int k = 0; k < WPL; k++) begin
            l = (lat < 0) ? int'($urandom_range(3)) : lat;
            for (int c = 0; c <= l; c++) begin
               exp_req       = 1'b1;
               exp_write     = 1'b0;
               exp_addr      = base + 32'(4 * k);
               mem_ack       = (c == l);
               mem_read_data = (c == l) ? memrd(base + 32'(4 * k)) : $urandom;
               step();
            end
         end
         mem_ack = 1'b0;
         for (int k = 0; k < WPL; k++) m_data[ln][k] = memrd(base + 32'(4 * k));
         m_valid[ln] = 1'b1;
         m_tag[ln]   = f_tag(a);
         idle_exp();
         exp_rdata = m_data[ln][wd];
         step();
      end else begin
         exp_stall = 1'b1;
         step();
         l = (lat < 0) ? int'($urandom_range(3)) : lat;
         for (int c = 0; c <= l; c++) begin
            exp_req   = 1'b1;
            exp_write = 1'b1;
            exp_addr  = a;
            exp_byte  = byt;
            exp_wdata = d;
            exp_stall = (c != l);
            mem_ack   = (c == l);
            step();
         end
         mem_ack = 1'b0;
         mem[a - (a % 4)] = merge(memrd(a - (a % 4)), d, byt, a);
         if (hit) m_data[ln][wd] = merge(m_data[ln][wd], d, byt, a);
      end
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      idle_exp();
   endtask

   // Read expected to hit: checks the returned word and the model against a hand-computed literal.
   task automatic read_pin(input logic [31:0] a, input logic [31:0] lit, input string nm);
      cpu_address = a;
      cpu_read    = 1'b1;
      idle_exp();
      exp_rdata = m_data[f_line(a)][f_word(a)];
      @(negedge clk);
      chk({nm, "_dut"}, cpu_read_data, lit);
      chk({nm, "_model"}, exp_rdata, lit);
      step();
      cpu_read = 1'b0;
      idle_exp();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      int          r;
      reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; write_or_byte = 1'b0;
      cpu_address = '0; cpu_write_data = '0; mem_ack = 1'b0; mem_read_data = '0;
      idle_exp();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      step();
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_byte", 32'(mem_byte), 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_mem_write_data", mem_write_data, 32'd0);
      chk("rst_cpu_read_data", cpu_read_data, 32'd0);
      step();
      reset  = 1'b1;
      chk_en = 1'b1;
      step();

      op(0, 0, 32'h40, 32'h0, 2);
      chk("miss_stall_cycles", 32'(stall_cnt), 32'd13);
      read_pin(32'h40, 32'h40, "refill_w0");
      read_pin(32'h48, 32'h48, "refill_w2");

      op(1, 0, 32'h44, 32'hDEADBEEF, 2);
      read_pin(32'h44, 32'hDEADBEEF, "word_write_hit");

      op(1, 0, 32'h44, 32'h11223344, 1);
      op(1, 1, 32'h46, 32'h000000A5, 1);
      chk("write_stall_cycles", 32'(stall_cnt), 32'd2);
      read_pin(32'h44, 32'h11A53344, "byte_write_hit");

      op(1, 0, 32'h200, 32'h12345678, 0);
      op(0, 0, 32'h200, 32'h0, 2);
      chk("no_write_allocate", 32'(stall_cnt), 32'd13);
      read_pin(32'h200, 32'h12345678, "nwa_data");

      op(0, 0, 32'h40, 32'h0, 2);
      chk("hit_no_stall", 32'(stall_cnt), 32'd0);
      op(0, 0, 32'h40 + 32'(4 * WPL * NL), 32'h0, 2);
      chk("conflict_miss", 32'(stall_cnt), 32'd13);
      op(0, 0, 32'h40, 32'h0, 2);
      chk("evicted_miss", 32'(stall_cnt), 32'd13);

      // Reset arrives during the second refill word of a miss to 0x240.
      chk_en      = 1'b0;
      cpu_address = 32'h240;
      cpu_read    = 1'b1;
      step();
      for (int c = 0; c <= 2; c++) begin
         mem_ack       = (c == 2);
         mem_read_data = 32'h240;
         step();
      end
      reset    = 1'b0;
      cpu_read = 1'b0;
      mem_ack  = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("abort_mem_req", 32'(mem_req), 32'd0);
      chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_cpu_read_data", cpu_read_data, 32'd0);
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      idle_exp();
      step();
      chk_en = 1'b1;
      op(0, 0, 32'h40, 32'h0, 2);
      chk("post_reset_miss", 32'(stall_cnt), 32'd13);

      for (int n = 0; n < 400; n++) begin
         a = (32'($urandom_range(3)) << 8) | (32'($urandom_range(NL - 1)) << 4) |
             (32'($urandom_range(WPL - 1)) << 2);
         r = int'($urandom_range(3));
         case (r)
            0, 1: op(0, 0, a, 32'h0, -1);
            2:    op(1, 0, a, $urandom, -1);
            default: op(1, 1, a | 32'($urandom_range(3)), $urandom, -1);
         endcase
         if ($urandom_range(3) == 0) step();
      end

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_cache.md
# data_cache

Parametrised direct-mapped, write-through, no-write-allocate data cache between the pipelined MIPS processor's memory stage and a multi-cycle backing data memory. Successor to the single-cycle data memory path: adds configurable capacity and line size, a request/acknowledge backing-memory handshake, and a `stall` output that freezes the pipeline on misses and write-throughs. Word and byte accesses are supported through the existing `write_or_byte` control.

## Interface
- `ADDR_WIDTH`, 32: byte address width, CPU and memory side.
- `NUM_LINES`, 16: cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `cpu_read` in 1: load in memory stage.
- `cpu_write` in 1: store in memory stage.
- `write_or_byte` in 1: 1 = byte access, 0 = word access.
- `cpu_address` in ADDR_WIDTH: byte address.
- `cpu_write_data` in 32: store data; byte stores use bits [7:0].
- `cpu_read_data` out 32: full word at word-aligned `cpu_address`; processor extracts bytes.
- `stall` out 1: pipeline must hold all memory-stage inputs stable while high.
- `mem_req` out 1: backing-memory request, held until `mem_ack`.
- `mem_write` out 1: 1 = write request, 0 = read.
- `mem_address` out ADDR_WIDTH: request address.
- `mem_write_data` out 32; `mem_byte` out 1: write payload and byte qualifier.
- `mem_ack` in 1: one-cycle completion pulse; valid only while `mem_req` high.
- `mem_read_data` in 32: valid in `mem_ack` cycle of a read.

## Operation
- Address split: offset [1:0], word index log2(WORDS_PER_LINE) bits, line index log2(NUM_LINES) bits, tag = remaining upper bits.
- Per line: valid bit, tag, WORDS_PER_LINE words. Hit = valid & tag match, combinational.
- Byte lanes little-endian: lane `cpu_address[1:0]` maps to bits [8*lane+7 : 8*lane].
- States: IDLE, REFILL, WRITE_THRU.
- IDLE, `cpu_write` = 1: to WRITE_THRU; `stall` = 1 same cycle. `cpu_write` takes priority over simultaneous `cpu_read`.
- IDLE, `cpu_read` & hit: `cpu_read_data` = cached word, `stall` = 0, no state change.
- IDLE, `cpu_read` & miss: to REFILL; `stall` = 1 same cycle.
- REFILL: `mem_req` = 1, `mem_write` = 0. Addresses start at word 0 of the line and increment by 4 after each ack. Each acked word is written to the array. On last ack: set valid, write tag, return to IDLE. Old line contents are overwritten; nothing is written back.
- WRITE_THRU: `mem_req` = 1, `mem_write` = 1, `mem_address` = `cpu_address`, `mem_byte` = `write_or_byte`, `mem_write_data` = `cpu_write_data`. On ack, if hit, update the cached word, or the single byte lane when `write_or_byte` = 1. A miss leaves the cache unchanged. Return to IDLE.
- `cpu_read_data` = 0 when not (IDLE & `cpu_read` & hit).
- `reset` low at any edge: state IDLE, all valid bits cleared, in-flight refill or write-through abandoned. Data and tag arrays are not cleared.

## Timing
- Reset values: `stall` 0, `mem_req` 0, `mem_write` 0, `mem_byte` 0, `mem_address` 0, `mem_write_data` 0, `cpu_read_data` 0.
- `stall` is combinational:
  - IDLE: (`cpu_read` & ~hit) | `cpu_write`.
  - REFILL: 1.
  - WRITE_THRU: ~`mem_ack`.
- Read hit: 0 added cycles.
- Read miss: `stall` high for WORDS_PER_LINE×(L+1)+1 cycles, where L = memory wait cycles between `mem_req` rise or address change and `mem_ack`. The cycle after the final ack is a hit with `stall` = 0.
- Write: `stall` high from the detect cycle through the cycle before ack. It is low in the ack cycle, so the pipeline advances at that edge.
- `mem_req` and its address/data are registered outputs, stable until ack. `mem_req` stays high across consecutive refill words.
- Ack arriving in the same cycle `mem_req` rises (L = 0) is legal.

## Structure
- Package `cache_pkg`:
  - state enum `cache_state_t` {IDLE, REFILL, WRITE_THRU}.
  - localparam functions for index, offset and tag widths.
  - byte-lane constants.
- Sub-module `cache_line_store`:
  - valid/tag/data arrays.
  - one combinational read port.
  - one synchronous write port with word and byte-lane enables.
  - synchronous valid clear.
- FSM and handshake logic live in `data_cache`.

## Test plan
- Reset then read 0x40 with L=2 memory returning address-as-data: `stall` high 13 cycles; four reads at 0x40, 0x44, 0x48, 0x4C; then `cpu_read_data` = 0x40 with `stall` = 0. A following read of 0x48 is a hit returning 0x48 with no stall.
- Word write 0xDEADBEEF to cached 0x44: one memory write, `stall` low in ack cycle; a following read of 0x44 is a hit returning 0xDEADBEEF.
- Byte write 0xA5 to 0x46 on a hit line holding 0x11223344: memory sees `mem_byte` = 1; cached word becomes 0x11A53344.
- Write to uncached 0x200: memory write issued; a following read of 0x200 misses and refills (no-write-allocate).
- Conflict: read 0x40, then 0x40 + 4×WORDS_PER_LINE×NUM_LINES: second access misses and evicts; re-reading 0x40 misses again.
- `reset` low during the second refill word: next cycle `mem_req` = 0, `stall` = 0, state IDLE; re-reading 0x40 misses.
